// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature pair to wrapping position, step pulses and per-frame delta
// Optional macro QUAD_X1_EN: count one step per full Gray cycle instead of every legal edge.
module quad_decoder #(
  parameter int FILTER_LEN = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             frame_strobe,
  output logic [CNT_W-1:0] position,
  output logic [CNT_W-1:0] delta,
  output logic             delta_valid,
  output logic             step_pulse,
  output logic             dir,
  output logic             err
);

  localparam int FC_W = 4;
  localparam logic [FC_W-1:0]  LEN     = FC_W'(FILTER_LEN);
  localparam logic [FC_W-1:0]  LEN_M1  = FC_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] ACC_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] ACC_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  typedef enum logic {INIT, TRACK} state_t;

  logic [1:0]       sync1, sync2;
  logic [1:0]       pending, filtered_ab, prev_ab;
  logic [FC_W-1:0]  match_cnt;
  logic             accept;
  state_t           state, state_next;
  logic             prev_load, step_fwd, step_rev, illegal, dir_next;
  logic [CNT_W-1:0] acc, acc_next;

  function automatic logic [1:0] gray_fwd(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_fwd = 2'b10;
      2'b10:   gray_fwd = 2'b11;
      2'b11:   gray_fwd = 2'b01;
      default: gray_fwd = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] gray_rev(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_rev = 2'b01;
      2'b01:   gray_rev = 2'b11;
      2'b11:   gray_rev = 2'b10;
      default: gray_rev = 2'b00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {quad_a, quad_b};
      sync2 <= sync1;
    end
  end

  // The reloading sample counts as the first of FILTER_LEN matching samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= '0;
      filtered_ab <= '0;
      match_cnt   <= '0;
      accept      <= 1'b0;
    end else begin
      accept <= 1'b0;
      if (ce) begin
        if (sync2 != pending) begin
          pending   <= sync2;
          match_cnt <= FC_W'(1);
          if (LEN_M1 == '0) begin
            filtered_ab <= sync2;
            accept      <= 1'b1;
          end
        end else if (match_cnt < LEN) begin
          match_cnt <= match_cnt + FC_W'(1);
          if (match_cnt == LEN_M1) begin
            filtered_ab <= pending;
            accept      <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    prev_load  = 1'b0;
    step_fwd   = 1'b0;
    step_rev   = 1'b0;
    illegal    = 1'b0;
    dir_next   = dir;
    case (state)
      INIT: begin
        if (accept) begin
          prev_load  = 1'b1;
          state_next = TRACK;
        end
      end
      default: begin
        if (accept && (filtered_ab != prev_ab)) begin
          prev_load = 1'b1;
          if (filtered_ab == gray_fwd(prev_ab)) begin
            dir_next = 1'b1;
`ifdef QUAD_X1_EN
            step_fwd = (prev_ab == 2'b01);
`else
            step_fwd = 1'b1;
`endif
          end else if (filtered_ab == gray_rev(prev_ab)) begin
            dir_next = 1'b0;
`ifdef QUAD_X1_EN
            step_rev = (prev_ab == 2'b10);
`else
            step_rev = 1'b1;
`endif
          end else begin
            illegal = 1'b1;
          end
        end
      end
    endcase
  end

  // Saturating accumulator; acc_next already holds this clock's step so a
  // coincident frame_strobe latches it into delta.
  always_comb begin
    acc_next = acc;
    if (step_fwd && (acc != ACC_MAX))
      acc_next = acc + CNT_W'(1);
    else if (step_rev && (acc != ACC_MIN))
      acc_next = acc - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      prev_ab     <= '0;
      position    <= '0;
      acc         <= '0;
      delta       <= '0;
      delta_valid <= 1'b0;
      step_pulse  <= 1'b0;
      dir         <= 1'b0;
      err         <= 1'b0;
    end else begin
      state <= state_next;
      if (prev_load)
        prev_ab <= filtered_ab;
      if (step_fwd)
        position <= position + CNT_W'(1);
      else if (step_rev)
        position <= position - CNT_W'(1);
      step_pulse  <= step_fwd | step_rev;
      dir         <= dir_next;
      err         <= illegal;
      delta_valid <= frame_strobe;
      if (frame_strobe) begin
        delta <= acc_next;
        acc   <= '0;
      end else begin
        acc <= acc_next;
      end
    end
  end

endmodule
